phase_edge_detector: RTL and testbench

- Upstream stage of the deser400 phase filter. Takes 8x-oversampled serial data, 8 samples per clk, and detects data transitions at each of the 8 sub-bit positions.
- Accumulates an edge histogram over a window of valid words. At window end, emits a one-cycle update strobe with the 3-bit dominant edge phase (2*pi phase), which feeds the filter's update/phase_in.
- Also flags loss of signal.

---
 rtl/phase_det_pkg.sv | 24 ++
 rtl/phase_edge_detector_if.sv | 32 +++
 rtl/phase_argmax.sv | 37 +++
 rtl/phase_edge_detector.sv | 172 +++++++++++++++++
 tb/tb_phase_edge_detector.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/phase_det_pkg.sv
// -----------------------------------------------------------------------------
// phase_det_pkg
// Shared constants and types for the phase edge detector slice.
//   NPH          : number of sub-bit sample positions per word (8x oversampling)
//   PH_W         : width of a phase index (0..NPH-1)
//   WIN_LOG2_DEF : default log2 of the histogram window length, in valid words
//   hist_cnt_t   : histogram bin type for the default window. One bit wider
//                  than WIN_LOG2, so a bin cannot overflow within a window.
//   cnt_width()  : bin width for an arbitrary WIN_LOG2
// -----------------------------------------------------------------------------
package phase_det_pkg;

    localparam int NPH          = 8;
    localparam int PH_W         = 3;
    localparam int WIN_LOG2_DEF = 4;

    // A bin sees at most one edge per word, so 2**WIN_LOG2 needs WIN_LOG2+1 bits.
    function automatic int cnt_width(input int win_log2);
        return win_log2 + 1;
    endfunction

    typedef logic [WIN_LOG2_DEF:0] hist_cnt_t;

endpackage

// File: rtl/phase_edge_detector_if.sv
// -----------------------------------------------------------------------------
// phase_edge_detector_if
// Groups the sample input and the window-result outputs of phase_edge_detector.
//   din_valid : din carries a new oversampled word this cycle
//   din[7:0]  : 8 samples, bit 0 oldest, bit 7 newest
//   update    : one-cycle strobe, phase holds a new window result
//   phase     : dominant edge position 0..7, held between updates
//   no_signal : high while the signal is considered absent
// Modports:
//   master : sample source / result consumer
//   slave  : the detector
// -----------------------------------------------------------------------------
interface phase_edge_detector_if;
    import phase_det_pkg::*;

    logic            din_valid;
    logic [NPH-1:0]  din;
    logic            update;
    logic [PH_W-1:0] phase;
    logic            no_signal;

    modport master (
        output din_valid, din,
        input  update, phase, no_signal
    );

    modport slave (
        input  din_valid, din,
        output update, phase, no_signal
    );

endinterface

// File: rtl/phase_argmax.sv
// -----------------------------------------------------------------------------
// phase_argmax
// Combinational 8-way maximum over histogram bins. Ties resolve to the lowest
// index. Also returns the sum of all bins.
//   cnt_i   : NPH bins of CNT_W bits
//   idx_o   : index of the largest bin (lowest index on ties)
//   total_o : sum of all bins, wide enough to avoid overflow
// -----------------------------------------------------------------------------
module phase_argmax
    import phase_det_pkg::*;
#(
    parameter int CNT_W = $bits(hist_cnt_t)
) (
    input  logic [NPH-1:0][CNT_W-1:0] cnt_i,
    output logic [PH_W-1:0]           idx_o,
    output logic [CNT_W+PH_W-1:0]     total_o
);

    localparam int TOT_W = CNT_W + PH_W;

    logic [CNT_W-1:0] best;

    always_comb begin
        idx_o   = '0;
        best    = cnt_i[0];
        total_o = '0;
        for (int i = 0; i < NPH; i++) begin
            total_o = total_o + TOT_W'(cnt_i[i]);
            // Strictly greater: an equal later bin never displaces an earlier one.
            if (cnt_i[i] > best) begin
                best  = cnt_i[i];
                idx_o = PH_W'(i);
            end
        end
    end

endmodule

// File: rtl/phase_edge_detector.sv
// -----------------------------------------------------------------------------
// phase_edge_detector
// Front end of the deser400 phase filter. Detects transitions at each of the 8
// sub-bit positions of an 8x-oversampled stream. It builds an edge histogram
// over a window of 2**WIN_LOG2 valid words. At window end it reports the
// dominant edge position with a one-cycle update strobe. It flags loss of signal
// after NOSIG_WINDOWS consecutive windows with fewer than MIN_EDGES edges.
//
// Ports:
//   clk     : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : phase_edge_detector_if.slave (din_valid, din, update, phase,
//             no_signal)
//
// Build option:
//   PHASE_EDGE_RISING_ONLY_EN : when defined, only rising (0->1) transitions
//                               count. When undefined, both polarities count.
//
// Timing: the word that closes a window is accepted on edge N. The snapshot is
// taken on edge N, evaluated during the following cycle, and registered on edge
// N+1, so update is high in the second cycle after the word was presented.
// -----------------------------------------------------------------------------
module phase_edge_detector
    import phase_det_pkg::*;
#(
    parameter int WIN_LOG2      = WIN_LOG2_DEF,
    parameter int MIN_EDGES     = 1,
    parameter int NOSIG_WINDOWS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    phase_edge_detector_if.slave  bus
);

    localparam int CW    = cnt_width(WIN_LOG2);
    localparam int TOT_W = CW + PH_W;
    localparam int EMP_W = $clog2(NOSIG_WINDOWS + 1);

    // ------------------------------------------------------------------
    // Edge vector
    // ------------------------------------------------------------------
    logic           prev_q;
    logic [NPH:0]   samples_ext;   // {din, prev}: position i is between ext[i] and ext[i+1]
    logic [NPH-1:0] edges;

    assign samples_ext = {bus.din, prev_q};

    genvar gi;
    generate
        for (gi = 0; gi < NPH; gi++) begin : g_edge
`ifdef PHASE_EDGE_RISING_ONLY_EN
            assign edges[gi] = samples_ext[gi+1] & ~samples_ext[gi];
`else
            assign edges[gi] = samples_ext[gi+1] ^ samples_ext[gi];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word counter and window framing
    // ------------------------------------------------------------------
    logic [WIN_LOG2-1:0] wcnt_q;
    logic                win_end;
    logic                eval_q;

    assign win_end = bus.din_valid && (wcnt_q == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            wcnt_q <= '0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= win_end;
            if (bus.din_valid) begin
                prev_q <= bus.din[NPH-1];
                wcnt_q <= wcnt_q + WIN_LOG2'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Histogram bins and window snapshot, one register pair per position
    // ------------------------------------------------------------------
    logic [NPH-1:0][CW-1:0] snap_all;

    generate
        for (gi = 0; gi < NPH; gi++) begin : g_bin
            logic [CW-1:0] hist_q;
            logic [CW-1:0] snap_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hist_q <= '0;
                    snap_q <= '0;
                end else if (bus.din_valid) begin
                    if (win_end) begin
                        // The closing word is part of the window. The next valid
                        // word starts a fresh window with no dead cycle.
                        snap_q <= hist_q + CW'(edges[gi]);
                        hist_q <= '0;
                    end else begin
                        hist_q <= hist_q + CW'(edges[gi]);
                    end
                end
            end

            assign snap_all[gi] = snap_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Evaluate stage
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  best_idx;
    logic [TOT_W-1:0] total;

    phase_argmax #(
        .CNT_W (CW)
    ) u_argmax (
        .cnt_i   (snap_all),
        .idx_o   (best_idx),
        .total_o (total)
    );

    logic             update_q, update_d;
    logic [PH_W-1:0]  phase_q,  phase_d;
    logic [EMP_W-1:0] empty_q,  empty_d;
    logic             nosig_q,  nosig_d;

    always_comb begin
        update_d = 1'b0;
        phase_d  = phase_q;
        empty_d  = empty_q;
        nosig_d  = nosig_q;
        if (eval_q) begin
            if (total >= TOT_W'(MIN_EDGES)) begin
                update_d = 1'b1;
                phase_d  = best_idx;
                empty_d  = '0;
                nosig_d  = 1'b0;
            end else begin
                // Saturate so that a long silence cannot wrap back below threshold.
                if (empty_q != EMP_W'(NOSIG_WINDOWS)) begin
                    empty_d = empty_q + EMP_W'(1);
                end
                if (empty_d == EMP_W'(NOSIG_WINDOWS)) begin
                    nosig_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            update_q <= 1'b0;
            phase_q  <= '0;
            empty_q  <= '0;
            nosig_q  <= 1'b1;
        end else begin
            update_q <= update_d;
            phase_q  <= phase_d;
            empty_q  <= empty_d;
            nosig_q  <= nosig_d;
        end
    end

    assign bus.update    = update_q;
    assign bus.phase     = phase_q;
    assign bus.no_signal = nosig_q;

endmodule

// File: tb/tb_phase_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_phase_edge_detector
// Directed and random stimulus for phase_edge_detector. A reference model built
// from the edge and histogram rules predicts every window result when the last
// word of the window is driven, and pushes it to a scoreboard. A negedge
// monitor pops each entry in the cycle it falls due. It checks update, phase
// and no_signal, and it checks that update stays low in every other cycle.
// PHASE_EDGE_RISING_ONLY_EN selects the same edge rule in the model as in the
// design.
// -----------------------------------------------------------------------------
module tb_phase_edge_detector;

    localparam int WIN_LOG2      = 4;
    localparam int MIN_EDGES     = 1;
    localparam int NOSIG_WINDOWS = 4;
    localparam int WIN           = 1 << WIN_LOG2;

    typedef struct {
        int         due;
        logic       upd;
        logic [2:0] ph;
        logic       ns;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    exp_t sb[$];

    // Reference model state
    logic       m_prev;
    int         m_hist[8];
    int         m_cnt;
    int         m_empty;
    logic [2:0] m_phase;
    logic       m_ns;

    phase_edge_detector_if bus();

    phase_edge_detector #(
        .WIN_LOG2      (WIN_LOG2),
        .MIN_EDGES     (MIN_EDGES),
        .NOSIG_WINDOWS (NOSIG_WINDOWS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev  = 1'b0;
        foreach (m_hist[i]) m_hist[i] = 0;
        m_cnt   = 0;
        m_empty = 0;
        m_phase = 3'd0;
        m_ns    = 1'b1;
        sb.delete();
    endtask

    // Drive one valid word and advance the model; predict the window result at window end.
    task automatic send(input logic [7:0] d);
        logic [8:0] x;
        exp_t       e;
        int         tot;
        int         best;
        int         bi;
        @(negedge clk);
        bus.din_valid = 1'b1;
        bus.din       = d;
        x = {d, m_prev};
        for (int i = 0; i < 8; i++) begin
`ifdef PHASE_EDGE_RISING_ONLY_EN
            m_hist[i] += int'(x[i+1] & ~x[i]);
`else
            m_hist[i] += int'(x[i+1] ^ x[i]);
`endif
        end
        m_prev = d[7];
        if (m_cnt == WIN - 1) begin
            tot  = 0;
            best = -1;
            bi   = 0;
            for (int i = 0; i < 8; i++) begin
                tot += m_hist[i];
                if (m_hist[i] > best) begin
                    best = m_hist[i];
                    bi   = i;
                end
            end
            if (tot >= MIN_EDGES) begin
                m_phase = bi[2:0];
                m_ns    = 1'b0;
                m_empty = 0;
                e.upd   = 1'b1;
            end else begin
                e.upd = 1'b0;
                if (m_empty < NOSIG_WINDOWS) m_empty++;
                if (m_empty == NOSIG_WINDOWS) m_ns = 1'b1;
            end
            e.due = cyc + 2;
            e.ph  = m_phase;
            e.ns  = m_ns;
            sb.push_back(e);
            foreach (m_hist[i]) m_hist[i] = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Idle cycles carry random garbage on din to show that it is ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.din       = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        chk("rst_update",    bus.update,    0);
        chk("rst_phase",     bus.phase,     0);
        chk("rst_no_signal", bus.no_signal, 1);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("win_update",    bus.update,    e.upd);
                chk("win_phase",     bus.phase,     e.ph);
                chk("win_no_signal", bus.no_signal, e.ns);
            end else begin
                chk("quiet_update", bus.update, 0);
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("missed_window", sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        model_reset();

        // Reset state
        do_reset();

        // Dominant phase: a single edge at position 3
        send(8'h00);
        send(8'hF8);
        repeat (14) send(8'hFF);
        idle(4);

        // Reset mid-window after lock: outputs clear at once, the partial window is dropped
        repeat (10) send(8'($urandom));
        do_reset();
        repeat (16) send(8'h3C);
        idle(4);

        // Tie-break: equal bins at positions 0 and 4 give the lower index
        do_reset();
        repeat (32) send(8'h0F);
        idle(3);

        // Loss of signal: four empty windows, then recovery
        repeat (64) send(8'h00);
        idle(3);
        chk("los_hold_no_signal", bus.no_signal, 1);
        repeat (16) send(8'h0F);
        idle(4);

        // Valid gaps are transparent: prev is held across the idle cycles
        do_reset();
        repeat (8) send(8'h80);
        idle(5);
        repeat (8) send(8'h81);
        idle(4);

        // Random words with random gaps over several windows
        do_reset();
        for (int w = 0; w < 5 * WIN; w++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
            send(8'($urandom));
        end
        idle(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
